// File: rtl/buffer_drain.sv
// rtl/buffer_drain.sv - Read-side sequencer that packs buffer words into 128-bit beats.
module buffer_drain #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [AddrWidth-1:0]   base_addr,
  input  logic [AddrWidth:0]     word_count,
  output logic                   readEn,
  output logic [AddrWidth-1:0]   readAddr,
  input  logic [DataWidth-1:0]   readData,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DataWidth-1:0] out_data,
  output logic [3:0]             out_mask,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [AddrWidth:0] MaxCount = {1'b1, {AddrWidth{1'b0}}};

  logic [1:0]             state;
  logic [AddrWidth-1:0]   base_q;
  logic [AddrWidth-1:0]   idx;
  logic [AddrWidth:0]     remain;
  logic [4*DataWidth-1:0] beat_q;
  logic [3:0]             mask_q;
  logic                   last_q;
  logic [AddrWidth:0]     count_clamped;
  logic [1:0]             lane;

  assign count_clamped = (word_count > MaxCount) ? MaxCount : word_count;
  assign lane          = idx[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      base_q <= '0;
      idx    <= '0;
      remain <= '0;
      beat_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count_clamped == '0) begin
              state <= DONE;
            end else begin
              base_q <= base_addr;
              idx    <= '0;
              remain <= count_clamped;
              beat_q <= '0;
              mask_q <= '0;
              last_q <= 1'b0;
              state  <= READ;
            end
          end
        end
        READ: begin
          for (int k = 0; k < 4; k++) begin
            if (lane == 2'(k)) beat_q[k*DataWidth +: DataWidth] <= readData;
          end
          mask_q[lane] <= 1'b1;
          idx          <= idx + 1'b1;
          remain       <= remain - 1'b1;
          // A beat closes on its fourth lane or on the final word, whichever comes first.
          if (lane == 2'd3 || remain == 1) begin
            last_q <= (remain == 1);
            state  <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (remain == '0) begin
              state <= DONE;
            end else begin
              beat_q <= '0;
              mask_q <= '0;
              state  <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Beat outputs are gated so nothing but zeros is visible outside OUT.
  assign readEn    = (state == READ);
  assign readAddr  = readEn ? (base_q + idx) : '0;
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? beat_q : '0;
  assign out_mask  = out_valid ? mask_q : 4'b0;
  assign out_last  = out_valid & last_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: doc/buffer_drain.md
# buffer_drain

Read-side sequencer for the shader data buffer. On a start pulse it walks a contiguous, wrapping range of 32-bit words using the buffer's `readEn`/`readAddr` port, which has a combinational read. It packs every four words into one 128-bit beat and delivers the beats on a valid/ready stream toward memory writeback. This is the inverse of the buffer's write path, which unpacks 128-bit writes into four consecutive words.

## Interface
- `DataWidth`, default 32: word width; beat width is `4*DataWidth`.
- `AddrWidth`, default 10: buffer word-address width; the address space is 1024 words.
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `base_addr`  in  AddrWidth: first word address; sampled with `start`.
- `word_count`  in  AddrWidth+1: number of words, 0..1024; values above 1024 are clamped to 1024; sampled with `start`.
- `readEn`  out  1: buffer read enable.
- `readAddr`  out  AddrWidth: buffer word address.
- `readData`  in  DataWidth: buffer read data; valid in the same cycle as `readEn`.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: downstream accept.
- `out_data`  out  4*DataWidth: packed beat; word k of the beat occupies bits [k*DataWidth +: DataWidth].
- `out_mask`  out  4: one bit per filled lane.
- `out_last`  out  1: marks the final beat of the transfer.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: one-cycle pulse at the end of a transfer.

## Operation
- FSM states: IDLE, READ, OUT, DONE.
- **IDLE**
  - `start` with `word_count` ≠ 0: latch `base_addr` and the clamped count, clear the lane register, go to READ.
  - `start` with `word_count` = 0: go to DONE; no beats are produced.
  - `start` outside IDLE is ignored.
- **READ**
  - Each cycle: `readEn`=1 and `readAddr` = (base + idx) mod 2^AddrWidth.
  - On that clock edge, capture `readData` into lane idx mod 4 and set the matching `out_mask` bit.
  - idx and the remaining-word count are updated on each captured word.
  - After the 4th lane, or after the last word, go to OUT.
- **OUT**
  - `out_valid`=1. `out_data`, `out_mask` and `out_last` are held stable until `out_valid && out_ready`.
  - `readEn`=0 throughout OUT.
  - On handshake, if words remain: clear lanes and mask, go to READ.
  - On handshake, if no words remain: go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- Unfilled lanes of a partial final beat are zero, and their `out_mask` bits are 0.
- `out_last`=1 only while the final beat is presented.
- Address wraps from 1023 to 0 with no error.
- Beats per transfer = ceil(N/4).
- The block never writes to the buffer.

## Timing
- **Reset:** asynchronous reset forces IDLE and drives all outputs to 0: `readEn`, `readAddr`, `out_valid`, `out_data`, `out_mask`, `out_last`, `busy`, `done`.
- **Reset mid-transfer:** the transfer is aborted, no `done` pulse is issued, and no partial beat is presented.
- **Cycle numbering:** `start` is sampled at edge E0.
  - `busy` is high from cycle 1.
  - Reads for beat 0 occur in cycles 1..n, where n = min(4, N).
  - `out_valid` rises in cycle n+1.
- **Throughput:** with `out_ready` held high, one full beat every 5 cycles.
- **Full N=4 transfer, `out_ready` high:** reads in cycles 1–4, beat in cycle 5, `done` in cycle 6, `busy` low in cycle 7.
- **`word_count`=0:** `done` in cycle 1, `busy` low in cycle 2.
- **Back-pressure:** while `out_ready`=0 in OUT, hold all beat outputs unchanged and issue no reads.
- **Combinational outputs:** `out_valid` has no combinational dependence on `out_ready`. `readEn` and `readAddr` are decoded from state only.

## Test plan
- **Reset values:** assert `rstn`=0 mid-sim → all outputs 0 asynchronously, before the next edge; `busy`=0.
- **Single full beat:** buffer words [0..3] = 0x11, 0x22, 0x33, 0x44; base=0, N=4, `out_ready`=1.
  - `readAddr` = 0, 1, 2, 3 in cycles 1–4.
  - Cycle 5: `out_data` = 0x00000044_00000033_00000022_00000011, `out_mask` = 4'hF, `out_last` = 1.
  - `done` in cycle 6.
- **Wrap and partial beat:** base=1022, N=6.
  - `readAddr` sequence: 1022, 1023, 0, 1, 2, 3.
  - Two beats; second beat has `out_mask` = 4'b0011, lanes 2–3 = 0, `out_last` = 1.
- **Back-pressure:** N=8, `out_ready`=0 for 3 cycles at the first beat.
  - `out_data` stable and `readEn`=0 during the stall.
  - The second beat's reads start the cycle after the handshake.
- **Zero count and ignored start:**
  - N=0 → `done` in cycle 1, no `out_valid`.
  - A second `start` issued during a N=8 transfer is ignored: exactly 2 beats and one `done`.
- **Reset mid-operation:** assert `rstn`=0 in the 2nd READ cycle → immediate IDLE with no `done`. A new N=4 transfer after release completes correctly.
